field_mac_seq: RTL

Sequential field multiply-accumulate engine that computes c = Σ a_i·b_i (mod p) over a stream of operand pairs. It sits directly upstream of consumers of field results and directly on top of the existing field arithmetic units. It owns one `field_multiplier` and one `field_adder`, and sequences them through their `en` / `ready_pulse` handshakes. Its result port mirrors those units (`ready_pulse`, `ready`, `c`), so it can drop into any datapath that currently chains them by hand.

---
 rtl/field_mac_seq_if.sv | 41 ++++
 rtl/field_mac_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_mac_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | field_mac_seq_if : start/operand/result bundle for field_mac_seq      |
// | Optional in_neg member when FIELD_MAC_NEG_EN is defined.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`ifndef F_NBITS
`define F_NBITS 8
`endif

interface field_mac_seq_if #(
  parameter int CW = 8
);
  logic                en;
  logic [CW-1:0]       count;
  logic                in_valid;
  logic [`F_NBITS-1:0] in_a;
  logic [`F_NBITS-1:0] in_b;
`ifdef FIELD_MAC_NEG_EN
  logic                in_neg;
`endif
  logic                in_ready;
  logic                ready_pulse;
  logic                ready;
  logic [`F_NBITS-1:0] c;

`ifdef FIELD_MAC_NEG_EN
  modport master (output en, count, in_valid, in_a, in_b, in_neg,
                  input  in_ready, ready_pulse, ready, c);
  modport slave  (input  en, count, in_valid, in_a, in_b, in_neg,
                  output in_ready, ready_pulse, ready, c);
`else
  modport master (output en, count, in_valid, in_a, in_b,
                  input  in_ready, ready_pulse, ready, c);
  modport slave  (input  en, count, in_valid, in_a, in_b,
                  output in_ready, ready_pulse, ready, c);
`endif
endinterface

`default_nettype wire

// File: rtl/field_mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | field_mac_seq : sequential c = sum(a_i*b_i) mod p over operand pairs |
// | Optional FIELD_MAC_NEG_EN adds in_neg and a field_subtract unit.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_PRIME
`define F_PRIME 251
`endif

// Two-cycle modular multiplier: raw product, then reduction.
module field_multiplier (
  input  wire logic                clk,
  input  wire logic                rstb,
  input  wire logic                en,
  input  wire logic [`F_NBITS-1:0] a,
  input  wire logic [`F_NBITS-1:0] b,
  output logic                     ready_pulse,
  output logic                     ready,
  output logic [`F_NBITS-1:0]      c
);
  localparam int FW = `F_NBITS;
  localparam int PW = 2 * FW;
  localparam logic [PW-1:0] c_prime = PW'(`F_PRIME);

  logic [PW-1:0] r_prod;
  logic          r_busy;
  logic          r_ready_pulse;
  logic [FW-1:0] r_c;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_prod        <= '0;
      r_busy        <= 1'b0;
      r_ready_pulse <= 1'b0;
      r_c           <= '0;
    end else begin
      r_ready_pulse <= 1'b0;
      if (r_busy) begin
        r_c           <= FW'(r_prod % c_prime);
        r_ready_pulse <= 1'b1;
        r_busy        <= 1'b0;
      end else if (en) begin
        r_prod <= PW'(a) * PW'(b);
        r_busy <= 1'b1;
      end
    end
  end

  assign ready_pulse = r_ready_pulse;
  assign ready       = ~r_busy & ~r_ready_pulse;
  assign c           = r_c;
endmodule

module field_adder (
  input  wire logic                clk,
  input  wire logic                rstb,
  input  wire logic                en,
  input  wire logic [`F_NBITS-1:0] a,
  input  wire logic [`F_NBITS-1:0] b,
  output logic                     ready_pulse,
  output logic                     ready,
  output logic [`F_NBITS-1:0]      c
);
  localparam int FW = `F_NBITS;
  localparam logic [FW:0] c_prime = (FW+1)'(`F_PRIME);

  logic [FW:0]   w_sum;
  logic          r_ready_pulse;
  logic [FW-1:0] r_c;

  assign w_sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ready_pulse <= 1'b0;
      r_c           <= '0;
    end else begin
      r_ready_pulse <= en;
      if (en) r_c <= (w_sum >= c_prime) ? FW'(w_sum - c_prime) : FW'(w_sum);
    end
  end

  assign ready_pulse = r_ready_pulse;
  assign ready       = ~r_ready_pulse;
  assign c           = r_c;
endmodule

`ifdef FIELD_MAC_NEG_EN
module field_subtract (
  input  wire logic                clk,
  input  wire logic                rstb,
  input  wire logic                en,
  input  wire logic [`F_NBITS-1:0] a,
  input  wire logic [`F_NBITS-1:0] b,
  output logic                     ready_pulse,
  output logic                     ready,
  output logic [`F_NBITS-1:0]      c
);
  localparam int FW = `F_NBITS;
  localparam logic [FW:0] c_prime = (FW+1)'(`F_PRIME);

  logic          r_ready_pulse;
  logic [FW-1:0] r_c;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ready_pulse <= 1'b0;
      r_c           <= '0;
    end else begin
      r_ready_pulse <= en;
      if (en) r_c <= (a >= b) ? (a - b) : FW'({1'b0, a} + c_prime - {1'b0, b});
    end
  end

  assign ready_pulse = r_ready_pulse;
  assign ready       = ~r_ready_pulse;
  assign c           = r_c;
endmodule
`endif

module field_mac_seq #(
  parameter int CW = 8
) (
  input  wire logic      clk,
  input  wire logic      rstb,
  field_mac_seq_if.slave bus
);
  localparam int FW = `F_NBITS;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_ADD, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_remain;
  logic [FW-1:0] r_acc, r_a, r_b, r_prod, r_c;
  logic          r_mul_en, r_add_en, r_in_ready, r_ready, r_ready_pulse;
  logic          w_mul_pulse, w_mul_ready, w_add_pulse, w_add_ready;
  logic          w_acc_pulse, w_units_idle;
  logic [FW-1:0] w_prod, w_sum, w_acc_next;

  field_multiplier u_mul (
    .clk(clk), .rstb(rstb), .en(r_mul_en), .a(r_a), .b(r_b),
    .ready_pulse(w_mul_pulse), .ready(w_mul_ready), .c(w_prod)
  );

  field_adder u_add (
    .clk(clk), .rstb(rstb), .en(r_add_en), .a(r_acc), .b(r_prod),
    .ready_pulse(w_add_pulse), .ready(w_add_ready), .c(w_sum)
  );

`ifdef FIELD_MAC_NEG_EN
  logic          r_neg, r_sub_en, w_sub_pulse, w_sub_ready;
  logic [FW-1:0] w_diff;

  field_subtract u_sub (
    .clk(clk), .rstb(rstb), .en(r_sub_en), .a(r_acc), .b(r_prod),
    .ready_pulse(w_sub_pulse), .ready(w_sub_ready), .c(w_diff)
  );

  // The term's sign decides which unit's strobe completes ADD.
  assign w_acc_pulse  = r_neg ? w_sub_pulse : w_add_pulse;
  assign w_acc_next   = r_neg ? w_diff : w_sum;
  assign w_units_idle = w_mul_ready & w_add_ready & w_sub_ready;
`else
  assign w_acc_pulse  = w_add_pulse;
  assign w_acc_next   = w_sum;
  assign w_units_idle = w_mul_ready & w_add_ready;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= S_IDLE;
      r_remain      <= '0;
      r_acc         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_prod        <= '0;
      r_c           <= '0;
      r_mul_en      <= 1'b0;
      r_add_en      <= 1'b0;
      r_in_ready    <= 1'b0;
      r_ready       <= 1'b1;
      r_ready_pulse <= 1'b0;
`ifdef FIELD_MAC_NEG_EN
      r_neg         <= 1'b0;
      r_sub_en      <= 1'b0;
`endif
    end else begin
      r_mul_en      <= 1'b0;
      r_add_en      <= 1'b0;
      r_ready_pulse <= 1'b0;
`ifdef FIELD_MAC_NEG_EN
      r_sub_en      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // The cycle after DONE re-raises ready before a new start is taken.
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (bus.en && w_units_idle) begin
            r_remain <= bus.count;
            r_acc    <= '0;
            r_ready  <= 1'b0;
            if (bus.count == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_FETCH;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
`ifdef FIELD_MAC_NEG_EN
            r_neg      <= bus.in_neg;
`endif
            r_in_ready <= 1'b0;
            r_mul_en   <= 1'b1;
            r_state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_mul_pulse) begin
            r_prod   <= w_prod;
`ifdef FIELD_MAC_NEG_EN
            r_add_en <= ~r_neg;
            r_sub_en <= r_neg;
`else
            r_add_en <= 1'b1;
`endif
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (w_acc_pulse) begin
            r_acc    <= w_acc_next;
            r_remain <= r_remain - CW'(1);
            if (r_remain == CW'(1)) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_FETCH;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_c           <= r_acc;
          r_ready_pulse <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.ready_pulse = r_ready_pulse;
  assign bus.ready       = r_ready;
  assign bus.c           = r_c;
endmodule

`default_nettype wire
